qoi_decoder: RTL and testbench
==============================

// Module: qoi_decoder
// PURPOSE
//  Memory-mapped QOI decoder peripheral on the 6502 bus; it mirrors the QOI encoder peripheral.
//  The CPU writes QOI chunk bytes into addr 0 and reads back decoded pixel bytes from addr 0.
//  Holds prev-pixel, 64-entry index and run state internally; stops after SIZE pixels.
// PARAMETERS
//  SIZE_W   30  width of pixel-count target/counter (regs 4..7)
//  IDX_N    64  index table entries (fixed by format; do not change)
// PORTS
//  clk     in   1   clock
//  rst     in   1   reset, synchronous, active-high
//  cs      in   1   chip select, 1 cycle per bus access
//  we      in   1   1=write, 0=read (valid with cs)
//  addr    in   3   register select
//  data_i  in   8   write data
//  data_o  out  8   read data, combinational from addr
//  irq     out  1   level: out_valid | done
// BEHAVIOUR
//  Regs: 0 W=chunk byte in, R=next pixel byte out; 3 W: bit7 start, bit0 clear;
//   3 R: {busy,done,0,0,byte_idx[1:0],out_valid,in_ready}; 4..7 W: size LE (bits 29:0);
//   4..7 R: decoded pixel count LE. Unmapped reads return 0, writes ignored.
//  Reset: state IDLE, prev=(0,0,0,FF), index all 0, count=0, run=0, byte_idx=0, data_o/irq=0.
//  FSM: IDLE -start-> OP; OP -tag byte-> ARG (RGB/RGBA/LUMA) or EMIT; ARG -last arg-> EMIT;
//   EMIT -all bytes popped-> RUN if run>0 else (count==size ? DONE : OP); DONE -start-> OP.
//  Start clears count/byte_idx/run; prev and index persist unless clear=1 (restores reset values).
//  in_ready=1 only in OP/ARG; writes to addr 0 with in_ready=0 are dropped (no error).
//  Tags: FE RGB(+r,g,b; a kept); FF RGBA(+r,g,b,a); 00xxxxxx INDEX; 01 DIFF; 10 LUMA(+1 byte);
//   11xxxxxx RUN len=b[5:0]+1 (1..62). FE/FF take priority over RUN decode.
//  DIFF: dr=b[5:4]-2, dg=b[3:2]-2, db=b[1:0]-2. LUMA: dg=b0[5:0]-32, dr=dg+b1[7:4]-8,
//   db=dg+b1[3:0]-8. All channel math modulo 256 (8-bit wrap, 0xFF+1=0x00).
//  Pixel latch: 1 cycle after final chunk byte write, out_valid=1, prev<=px,
//   index[(r*3+g*5+b*7+a*11)%64]<=px, count+=1 (INDEX op rewrites same slot, harmless).
//  Output: read addr 0 with out_valid returns channel byte_idx (r,g,b[,a]) and advances byte_idx;
//   last byte clears out_valid next cycle. Read with out_valid=0 returns 00, no side effect.
//  RUN: each repeat re-emits prev and counts; ends early at count==size (remaining run discarded).
//  done=1 in DONE; busy=1 in OP/ARG/EMIT/RUN. Trailing end marker bytes in DONE ignored.
//  Start written mid-decode restarts at OP (partial chunk discarded). Reset mid-op -> reset values.
//  size=0 with start: go straight to DONE, count=0.
// CONFIGURATION
//  QOI_DEC_ALPHA_EN defined: 4 output bytes per pixel (r,g,b,a), byte_idx wraps at 3.
//  Undefined: 3 output bytes (r,g,b), byte_idx wraps at 2; alpha still tracked for RGBA
//   ops and hash. Register map and status bits identical in both builds.
// TESTING
//  1 rst; size=1; start; wr FF,10,20,30,40 -> reads 10,20,30,40 [ALPHA_EN], count=1, done=1, irq=1.
//  2 rst; size=3; start; wr C2 -> 3 pixels 00,00,00,FF; in_ready=0 until last byte popped; done.
//  3 rst; size=3; wr 7F, 40, A8 9F -> (01,01,01,FF), (FF,FF,FF,FF), (08,07,0E,FF) (wrap checked).
//  4 size=3; wr FF 10 20 30 40, FE 00 00 00, 20 -> (10,20,30,40), (00,00,00,40), (10,20,30,40) via slot 32.
//  5 size=2; wr FD (run 62) -> exactly 2 pixels emitted, done, count=2; further wr 00 ignored.
//  6 rd addr0 with out_valid=0 -> 00, byte_idx unchanged; wr during EMIT dropped; rst after FF,10 ->
//    status 00, prev=(0,0,0,FF); next start+RGBA decodes correctly.

Source files
------------

// File: rtl/qoi_decoder_if.sv
// 6502-style register bus between the CPU and the QOI decoder peripheral.
interface qoi_decoder_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       irq;

  modport master (output cs, we, addr, data_i, input data_o, irq);
  modport slave  (input cs, we, addr, data_i, output data_o, irq);
endinterface

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI chunk decoder: chunk bytes in at reg 0, pixel bytes out at reg 0.
// Define QOI_DEC_ALPHA_EN to emit r,g,b,a per pixel instead of r,g,b.
module qoi_decoder #(
  parameter int SIZE_W = 30,
  parameter int IDX_N  = 64
) (
  input  logic         clk,
  input  logic         rst,
  qoi_decoder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_EMIT, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  localparam pixel_t PX_RESET = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

`ifdef QOI_DEC_ALPHA_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  state_t              state_q, state_n;
  pixel_t              prev_q;
  pixel_t              index_q [IDX_N];
  logic [SIZE_W-1:0]   count_q;
  logic [SIZE_W-1:0]   size_q;
  logic [5:0]          run_q;
  logic [1:0]          byte_idx_q;
  logic                out_valid_q;
  logic [7:0]          tag_q;
  logic [1:0]          arg_cnt_q;
  logic [7:0]          arg_q [4];

  // Bus decode
  logic in_ready, chunk_wr, ctrl_wr, start, clear, size_wr, pop, pop_last;
  logic busy, done;

  assign in_ready = (state_q == S_OP) || (state_q == S_ARG);
  assign chunk_wr = bus.cs && bus.we && (bus.addr == 3'd0) && in_ready;
  assign ctrl_wr  = bus.cs && bus.we && (bus.addr == 3'd3);
  assign start    = ctrl_wr && bus.data_i[7];
  assign clear    = ctrl_wr && bus.data_i[0];
  assign size_wr  = bus.cs && bus.we && bus.addr[2];
  assign pop      = bus.cs && !bus.we && (bus.addr == 3'd0) && out_valid_q;
  assign pop_last = pop && (byte_idx_q == LAST_BYTE);
  assign busy     = (state_q == S_OP) || (state_q == S_ARG) ||
                    (state_q == S_EMIT) || (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

  // In OP the tag is the byte on the bus; in ARG it is the one captured earlier.
  logic [7:0] cur_tag;
  logic       is_rgb, is_rgba, is_luma, is_run, needs_arg, arg_last, latch;

  assign cur_tag   = (state_q == S_OP) ? bus.data_i : tag_q;
  assign is_rgb    = (cur_tag == 8'hFE);
  assign is_rgba   = (cur_tag == 8'hFF);
  assign is_luma   = (cur_tag[7:6] == 2'b10);
  assign is_run    = (cur_tag[7:6] == 2'b11) && !is_rgb && !is_rgba;
  assign needs_arg = is_rgb || is_rgba || is_luma;
  assign arg_last  = (is_rgb && arg_cnt_q == 2'd2) || (is_rgba && arg_cnt_q == 2'd3) || is_luma;
  assign latch     = (chunk_wr && state_q == S_OP && !needs_arg) ||
                     (chunk_wr && state_q == S_ARG && arg_last) ||
                     (state_q == S_RUN);

  // Pixel produced by the chunk completing this cycle (channel math wraps at 8 bits)
  pixel_t     px;
  logic [7:0] dg;
  logic [5:0] hash;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    px = prev_q;
    dg = 8'h00;
    if (state_q == S_OP) begin
      case (bus.data_i[7:6])
        2'b00: px = index_q[bus.data_i[5:0]];
        2'b01: begin
          px.r = prev_q.r + {6'b0, bus.data_i[5:4]} - 8'd2;
          px.g = prev_q.g + {6'b0, bus.data_i[3:2]} - 8'd2;
          px.b = prev_q.b + {6'b0, bus.data_i[1:0]} - 8'd2;
        end
        default: px = prev_q;
      endcase
    end else if (state_q == S_ARG) begin
      if (is_rgb) begin
        px.r = arg_q[0];
        px.g = arg_q[1];
        px.b = bus.data_i;
      end else if (is_rgba) begin
        px.r = arg_q[0];
        px.g = arg_q[1];
        px.b = arg_q[2];
        px.a = bus.data_i;
      end else begin
        dg   = {2'b00, tag_q[5:0]} - 8'd32;
        px.g = prev_q.g + dg;
        px.r = prev_q.r + dg + {4'b0, bus.data_i[7:4]} - 8'd8;
        px.b = prev_q.b + dg + {4'b0, bus.data_i[3:0]} - 8'd8;
      end
    end
    hash = 6'(px.r * 8'd3 + px.g * 8'd5 + px.b * 8'd7 + px.a * 8'd11);
  end

  // Byte-lane update of the little-endian size register
  logic [31:0] size_wr_val;
  always_comb begin
    size_wr_val = 32'(size_q);
    size_wr_val[{bus.addr[1:0], 3'b000} +: 8] = bus.data_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (start) begin
      state_n = (size_q == '0) ? S_DONE : S_OP;
    end else begin
      case (state_q)
        S_OP:   if (chunk_wr) state_n = needs_arg ? S_ARG : S_EMIT;
        S_ARG:  if (chunk_wr && arg_last) state_n = S_EMIT;
        S_EMIT: if (pop_last) begin
          if (count_q >= size_q)  state_n = S_DONE;
          else if (run_q != 6'd0) state_n = S_RUN;
          else                    state_n = S_OP;
        end
        S_RUN:  state_n = S_EMIT;
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= PX_RESET;
      // NOTE: the index table is reset on purpose; the format defines it as all-zero at start.
      for (int i = 0; i < IDX_N; i++) index_q[i] <= '0;
      count_q     <= '0;
      size_q      <= '0;
      run_q       <= '0;
      byte_idx_q  <= '0;
      out_valid_q <= 1'b0;
      tag_q       <= '0;
      arg_cnt_q   <= '0;
      for (int i = 0; i < 4; i++) arg_q[i] <= '0;
    end else begin
      if (size_wr) size_q <= SIZE_W'(size_wr_val);
      if (start) begin
        count_q     <= '0;
        byte_idx_q  <= '0;
        run_q       <= '0;
        out_valid_q <= 1'b0;
        arg_cnt_q   <= '0;
      end else begin
        if (chunk_wr && state_q == S_OP) begin
          tag_q     <= bus.data_i;
          arg_cnt_q <= '0;
          if (is_run) run_q <= bus.data_i[5:0];
        end
        if (chunk_wr && state_q == S_ARG) begin
          arg_q[arg_cnt_q] <= bus.data_i;
          arg_cnt_q        <= arg_cnt_q + 2'd1;
        end
        if (state_q == S_RUN) run_q <= run_q - 6'd1;
        if (latch) begin
          prev_q        <= px;
          index_q[hash] <= px;
          count_q       <= count_q + 1'b1;
          out_valid_q   <= 1'b1;
          byte_idx_q    <= '0;
        end
        if (pop) begin
          if (pop_last) begin
            out_valid_q <= 1'b0;
            byte_idx_q  <= '0;
          end else begin
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
      end
      // Placed last so a clear wins over any pixel latched in the same cycle
      if (clear) begin
        prev_q <= PX_RESET;
        for (int i = 0; i < IDX_N; i++) index_q[i] <= '0;
      end
    end
  end

  logic [31:0] count_ext;
  assign count_ext = 32'(count_q);

  always_comb begin
    bus.data_o = 8'h00;
    case (bus.addr)
      3'd0: if (out_valid_q) begin
        case (byte_idx_q)
          2'd0:    bus.data_o = prev_q.r;
          2'd1:    bus.data_o = prev_q.g;
          2'd2:    bus.data_o = prev_q.b;
          default: bus.data_o = prev_q.a;
        endcase
      end
      3'd3: bus.data_o = {busy, done, 2'b00, byte_idx_q, out_valid_q, in_ready};
      3'd4, 3'd5, 3'd6, 3'd7: bus.data_o = count_ext[{bus.addr[1:0], 3'b000} +: 8];
      default: bus.data_o = 8'h00;
    endcase
  end

  assign bus.irq = out_valid_q || done;

endmodule

// File: tb/tb_qoi_decoder.sv
// Scoreboard bench for qoi_decoder: expected pixel bytes are queued as chunks are written
// and compared as the CPU reads them back.
module tb_qoi_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qoi_decoder_if bus();
  qoi_decoder dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    d = bus.data_o;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_size(input int n);
    for (int k = 0; k < 4; k++) wr(3'(4 + k), 8'(n >> (8 * k)));
  endtask

  task automatic push_px(input logic [7:0] r, g, b, a);
    sb.push_back(r); sb.push_back(g); sb.push_back(b);
`ifdef QOI_DEC_ALPHA_EN
    sb.push_back(a);
`endif
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    logic [7:0] st;
    rd(3'd3, st);
    check(tag, st, exp);
  endtask

  task automatic check_count(input string tag, input int exp);
    logic [7:0]  b;
    logic [31:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      rd(3'(4 + k), b);
      c[8*k +: 8] = b;
    end
    check(tag, c, exp);
  endtask

  // Poll out_valid with a bounded budget, then pop and compare every queued byte
  task automatic drain();
    logic [7:0] st, d;
    bit ok;
    while (sb.size() > 0) begin
      ok = 1'b0;
      st = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
        rd(3'd3, st);
        ok = st[1];
      end
      if (!ok) begin
        check("out_valid_timeout", {31'b0, st[1]}, 32'd1);
        sb.delete();
        return;
      end
      rd(3'd0, d);
      check("pixel_byte", d, sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
    do_reset();

    // Reset state
    check_status("rst_status", 8'h00);
    check_count("rst_count", 0);
    rd(3'd0, d);
    check("rst_data", d, 8'h00);
    check("rst_irq", {31'b0, bus.irq}, 32'd0);

    // 1: single RGBA pixel
    set_size(1);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'hFF); wr(3'd0, 8'h10); wr(3'd0, 8'h20); wr(3'd0, 8'h30); wr(3'd0, 8'h40);
    push_px(8'h10, 8'h20, 8'h30, 8'h40);
    drain();
    check_count("t1_count", 1);
    check_status("t1_done", 8'h40);
    check("t1_irq", {31'b0, bus.irq}, 32'd1);

    // 2: run of 3 from the reset prev pixel
    do_reset();
    set_size(3);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'hC2);
    check_status("t2_emit_status", 8'h82);
    push_px(8'h00, 8'h00, 8'h00, 8'hFF);
    drain();
    rd(3'd3, d);
    check("t2_in_ready", {31'b0, d[0]}, 32'd0);
    push_px(8'h00, 8'h00, 8'h00, 8'hFF);
    push_px(8'h00, 8'h00, 8'h00, 8'hFF);
    drain();
    check_status("t2_done", 8'h40);
    check_count("t2_count", 3);

    // 3: DIFF and LUMA with channel wrap
    do_reset();
    set_size(3);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h7F); push_px(8'h01, 8'h01, 8'h01, 8'hFF); drain();
    wr(3'd0, 8'h40); push_px(8'hFF, 8'hFF, 8'hFF, 8'hFF); drain();
    wr(3'd0, 8'hA8); wr(3'd0, 8'h9F); push_px(8'h08, 8'h07, 8'h0E, 8'hFF); drain();
    check_count("t3_count", 3);
    check_status("t3_done", 8'h40);

    // 4: RGBA, RGB keeping alpha, INDEX hit on slot 32
    set_size(3);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'hFF); wr(3'd0, 8'h10); wr(3'd0, 8'h20); wr(3'd0, 8'h30); wr(3'd0, 8'h40);
    push_px(8'h10, 8'h20, 8'h30, 8'h40); drain();
    wr(3'd0, 8'hFE); wr(3'd0, 8'h00); wr(3'd0, 8'h00); wr(3'd0, 8'h00);
    push_px(8'h00, 8'h00, 8'h00, 8'h40); drain();
    wr(3'd0, 8'h20);
    push_px(8'h10, 8'h20, 8'h30, 8'h40); drain();
    check_status("t4_done", 8'h40);

    // prev persists across start; clear restores prev and zeroes the index
    set_size(1);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h6A); push_px(8'h10, 8'h20, 8'h30, 8'h40); drain();
    set_size(2);
    wr(3'd3, 8'h81);
    wr(3'd0, 8'h6A); push_px(8'h00, 8'h00, 8'h00, 8'hFF); drain();
    wr(3'd0, 8'h20); push_px(8'h00, 8'h00, 8'h00, 8'h00); drain();
    check_count("clear_count", 2);

    // 5: long run cut short by size
    set_size(3);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h55); push_px(8'hFF, 8'hFF, 8'hFF, 8'h00); drain();
    wr(3'd0, 8'hFD);
    push_px(8'hFF, 8'hFF, 8'hFF, 8'h00);
    push_px(8'hFF, 8'hFF, 8'hFF, 8'h00);
    drain();
    check_count("t5_count", 3);
    wr(3'd0, 8'h00);
    check_status("t5_done_after_wr", 8'h40);
    check_count("t5_count_after_wr", 3);

    // 6: empty read, dropped write during EMIT, reset mid-chunk
    do_reset();
    set_size(2);
    wr(3'd3, 8'h80);
    rd(3'd0, d);
    check("t6_empty_read", d, 8'h00);
    check_status("t6_status_op", 8'h81);
    wr(3'd0, 8'hFF); wr(3'd0, 8'h10);
    do_reset();
    check_status("t6_rst_status", 8'h00);
    check_count("t6_rst_count", 0);
    set_size(2);
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h6A);
    push_px(8'h00, 8'h00, 8'h00, 8'hFF);
    wr(3'd0, 8'h00);
    rd(3'd0, d);
    check("t6_first_byte", d, sb.pop_front());
    check_status("t6_byte_idx", 8'h86);
    drain();
    wr(3'd0, 8'hFF); wr(3'd0, 8'h11); wr(3'd0, 8'h22); wr(3'd0, 8'h33); wr(3'd0, 8'h44);
    push_px(8'h11, 8'h22, 8'h33, 8'h44);
    drain();
    check_status("t6_done", 8'h40);
    check_count("t6_count", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
